regfile_wb_arbiter: RTL and testbench
=====================================

# regfile_wb_arbiter

Write-back arbiter and pending-write scoreboard for the 16x32 register file. It shares the single general write port (`RegWrite`/`Rd`/`BusW`) among `NREQ` write-back requesters (ALU, load, multi-cycle unit) using round-robin priority and a valid/ready handshake. It drives the port from registered outputs. Per-register pending counters export `busy[15:0]` to the hazard/stall logic. R15 (PC) is written only through the dedicated PC port, so this block never writes it.

## Interface
- `NREQ`, 3: number of write-back requesters (2..4).
- `CNT_W`, 2: width of each per-register pending counter; saturates at 2^CNT_W-1.
- `clk`  in  1  single clock, all state on rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `req_valid`  in  NREQ  requester i has a write pending.
- `req_rd`  in  4*NREQ  destination of requester i, bits [4i+3:4i].
- `req_data`  in  32*NREQ  write data of requester i, bits [32i+31:32i].
- `req_ready`  out  NREQ  one-hot-or-zero grant; transfer when `req_valid[i] & req_ready[i]`.
- `reserve_valid`  in  1  issue stage reserves a destination.
- `reserve_rd`  in  4  register being reserved.
- `reserve_ready`  out  1  reservation accepted this cycle.
- `busy`  out  16  bit r = pending counter r nonzero.
- `wb_we`  out  1  to register file `RegWrite`.
- `wb_rd`  out  4  to register file `Rd`.
- `wb_data`  out  32  to register file `BusW`.
- `err_r15`  out  1  one-cycle pulse on a write or reserve targeting R15.
- `err_unres`  out  1  one-cycle pulse on a write to a register whose counter is 0.

## Operation
- Round-robin pointer `ptr` (0..NREQ-1). The grant goes to the first valid requester scanning ptr, ptr+1, … mod NREQ.
- `req_ready` is combinational from `req_valid` and `ptr`. It never depends on `req_ready` of another requester. At most one requester transfers per cycle.
- After a transfer from requester g, `ptr` <= (g+1) mod NREQ. With no transfer, `ptr` holds.
- On transfer with rd != 15: next edge `wb_we`=1, `wb_rd`=rd, `wb_data`=data, and counter[rd] decrements.
- On transfer with rd == 15: the request is consumed, `wb_we` stays 0 next cycle, `err_r15` pulses, and no counter changes.
- On transfer with counter[rd]==0 (rd != 15): the write still goes out, the counter stays 0 (no underflow), and `err_unres` pulses.
- `reserve_ready` = `reserve_valid` & `reserve_rd`!=15 & counter[reserve_rd] != max.
  - An accepted reserve increments counter[reserve_rd].
  - A reserve for R15 is dropped and pulses `err_r15`.
  - A reserve on a saturated counter is refused; issue must hold and retry.
- Reserve and write to the same rd in the same cycle: the counter is unchanged (+1-1). This is legal even at max, so `reserve_ready` also counts a same-cycle write to that rd.
- `busy[r]` = |counter[r]. It is combinational from the registered counters. `busy[15]` is always 0.

## Timing
- Reset (async assert, sync-clean deassert):
  - `ptr`=0 and all counters=0.
  - `wb_we`=0, `wb_rd`=0, `wb_data`=0, `err_r15`=0, `err_unres`=0.
  - Hence `busy`=0; `req_ready` and `reserve_ready` follow inputs combinationally.
- Handshake to `wb_we`: 1 cycle. `wb_*` is valid for exactly one cycle per transfer. Back-to-back transfers give continuous `wb_we`.
- `busy[rd]` clears on the same cycle `wb_we` presents that rd. The register file's same-cycle bypass covers the read.
- Reserve to `busy` set: 1 cycle.
- Error pulses are registered and align with the cycle `wb_we` would assert.
- Reset mid-operation: in-flight `wb_we` is cleared immediately, and all pending reservations are lost.

## Test plan
- Reset, then reserve R3, then requester 1 writes R3 = 0xDEADBEEF → `busy[3]`=1 after 1 cycle; `wb_we`=1, `wb_rd`=3, `wb_data`=0xDEADBEEF one cycle after the transfer; `busy[3]`=0 that same cycle.
- All three requesters valid continuously, each reserved beforehand (R1, R2, R4) → grants in order 0,1,2,0,… with `ptr` rotating; `wb_we` is high every cycle.
- Reserve R5 three times (CNT_W=2) → `busy[5]`=1 and counter=3. A 4th reserve gets `reserve_ready`=0; the same reserve plus a same-cycle write to R5 gets `reserve_ready`=1 and the counter stays 3.
- Requester 0 writes R15 = 0x100 → `req_ready[0]`=1, next cycle `wb_we`=0 and `err_r15`=1 for one cycle; a reserve of R15 likewise pulses `err_r15` with `reserve_ready`=0.
- Write to unreserved R7 = 0x5 → `wb_we`=1, `wb_rd`=7, `err_unres`=1, and `busy[7]` stays 0.
- Reserve R2, assert `rst_n`=0 mid-cycle while requester 2 transfers → `wb_we` drops immediately, `busy`=0, and `ptr` restarts at 0.

Source files
------------

// File: rtl/regfile_wb_arbiter_if.sv
// Write-back arbiter bus: requester handshakes, reservations,
// scoreboard status and the register-file write port.
interface regfile_wb_arbiter_if #(
  parameter int NREQ = 3
);
  logic [NREQ-1:0]    req_valid;
  logic [4*NREQ-1:0]  req_rd;
  logic [32*NREQ-1:0] req_data;
  logic [NREQ-1:0]    req_ready;
  logic               reserve_valid;
  logic [3:0]         reserve_rd;
  logic               reserve_ready;
  logic [15:0]        busy;
  logic               wb_we;
  logic [3:0]         wb_rd;
  logic [31:0]        wb_data;
  logic               err_r15;
  logic               err_unres;

  modport master (
    output req_valid, req_rd, req_data,
    output reserve_valid, reserve_rd,
    input  req_ready, reserve_ready, busy,
    input  wb_we, wb_rd, wb_data,
    input  err_r15, err_unres
  );

  modport slave (
    input  req_valid, req_rd, req_data,
    input  reserve_valid, reserve_rd,
    output req_ready, reserve_ready, busy,
    output wb_we, wb_rd, wb_data,
    output err_r15, err_unres
  );
endinterface

// File: rtl/regfile_wb_arbiter.sv
// Round-robin write-back arbiter for the shared register-file
// write port, with per-register pending-write counters.
module regfile_wb_arbiter #(
  parameter int NREQ  = 3,
  parameter int CNT_W = 2
) (
  input logic clk,
  input logic rst_n,
  regfile_wb_arbiter_if.slave bus
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam logic [CNT_W-1:0] CMAX = '1;
  localparam logic [3:0] R15 = 4'd15;

  logic [PW-1:0]    ptr_q, ptr_d;
  logic [CNT_W-1:0] cnt_q [16];
  logic [CNT_W-1:0] cnt_d [16];

  logic [NREQ-1:0] gnt;
  logic [PW-1:0]   gidx;
  logic            xfer;
  logic [3:0]      xrd;
  logic [31:0]     xdata;
  logic            wr_ok;
  logic            res_ok;
  logic            res_r15;
  logic            xfer_r15;
  logic [15:0]     busy_w;

  logic            wb_we_q;
  logic [3:0]      wb_rd_q;
  logic [31:0]     wb_data_q;
  logic            err_r15_q;
  logic            err_unres_q;

  // First valid requester scanning from ptr, wrapping modulo NREQ
  always_comb begin
    xfer = 1'b0;
    gidx = '0;
    for (int k = 0; k < NREQ; k++) begin
      int idx;
      idx = int'(ptr_q) + k;
      if (idx >= NREQ) idx = idx - NREQ;
      if (!xfer && bus.req_valid[idx]) begin
        xfer = 1'b1;
        gidx = PW'(idx);
      end
    end
    gnt = '0;
    if (xfer) gnt[gidx] = 1'b1;
  end

  assign xrd      = bus.req_rd[int'(gidx)*4 +: 4];
  assign xdata    = bus.req_data[int'(gidx)*32 +: 32];
  assign wr_ok    = xfer && (xrd != R15);
  assign xfer_r15 = xfer && (xrd == R15);
  assign res_r15  = bus.reserve_valid &&
                    (bus.reserve_rd == R15);

  // A same-cycle write to the reserved rd frees a slot, so a
  // saturated counter can still take the reservation.
  assign res_ok = bus.reserve_valid &&
                  (bus.reserve_rd != R15) &&
                  ((cnt_q[bus.reserve_rd] != CMAX) ||
                   (wr_ok && (xrd == bus.reserve_rd)));

  assign bus.req_ready     = gnt;
  assign bus.reserve_ready = res_ok;

  // Pointer advances past the granted requester
  always_comb begin
    ptr_d = ptr_q;
    if (xfer) begin
      if (gidx == PW'(NREQ - 1)) ptr_d = '0;
      else                       ptr_d = gidx + 1'b1;
    end
  end

  // Counter update: +1 on reserve, -1 on write, hold on both
  always_comb begin
    for (int r = 0; r < 16; r++) begin
      logic inc;
      logic dec;
      inc = res_ok && (bus.reserve_rd == 4'(r));
      dec = wr_ok && (xrd == 4'(r));
      cnt_d[r] = cnt_q[r];
      if (inc && !dec) begin
        cnt_d[r] = cnt_q[r] + 1'b1;
      end else if (dec && !inc && (cnt_q[r] != '0)) begin
        cnt_d[r] = cnt_q[r] - 1'b1;
      end
    end
  end

  // Busy flags straight from the registered counters
  always_comb begin
    for (int r = 0; r < 16; r++) busy_w[r] = |cnt_q[r];
    busy_w[15] = 1'b0;
  end

  assign bus.busy = busy_w;

  // Arbiter pointer and scoreboard counters
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q <= '0;
      for (int r = 0; r < 16; r++) cnt_q[r] <= '0;
    end else begin
      ptr_q <= ptr_d;
      for (int r = 0; r < 16; r++) cnt_q[r] <= cnt_d[r];
    end
  end

  // Registered write port and error pulses
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wb_we_q     <= 1'b0;
      wb_rd_q     <= '0;
      wb_data_q   <= '0;
      err_r15_q   <= 1'b0;
      err_unres_q <= 1'b0;
    end else begin
      wb_we_q     <= wr_ok;
      err_r15_q   <= xfer_r15 || res_r15;
      err_unres_q <= wr_ok && (cnt_q[xrd] == '0);
      if (wr_ok) begin
        wb_rd_q   <= xrd;
        wb_data_q <= xdata;
      end
    end
  end

  assign bus.wb_we     = wb_we_q;
  assign bus.wb_rd     = wb_rd_q;
  assign bus.wb_data   = wb_data_q;
  assign bus.err_r15   = err_r15_q;
  assign bus.err_unres = err_unres_q;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Bench for regfile_wb_arbiter: directed scenarios plus random
// traffic against a counter/pointer reference model.
module tb_regfile_wb_arbiter;

  localparam int N    = 3;
  localparam int CMAX = 3;

  logic clk;
  logic rst_n;

  regfile_wb_arbiter_if #(.NREQ(N)) bus();

  regfile_wb_arbiter #(.NREQ(N), .CNT_W(2)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  int          mcnt [16];
  int          mptr;
  logic        e_we;
  logic [3:0]  e_rd;
  logic [31:0] e_data;
  logic        e_r15;
  logic        e_unres;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int r = 0; r < 16; r++) mcnt[r] = 0;
    mptr    = 0;
    e_we    = 1'b0;
    e_rd    = '0;
    e_data  = '0;
    e_r15   = 1'b0;
    e_unres = 1'b0;
  endtask

  task automatic chk_regs();
    logic [15:0] eb;
    for (int r = 0; r < 16; r++) eb[r] = (mcnt[r] > 0);
    chk("wb_we", bus.wb_we, e_we);
    if (e_we) begin
      chk("wb_rd", bus.wb_rd, e_rd);
      chk("wb_data", bus.wb_data, e_data);
    end
    chk("err_r15", bus.err_r15, e_r15);
    chk("err_unres", bus.err_unres, e_unres);
    chk("busy", bus.busy, eb);
  endtask

  // One clock: drive at edge+1, check handshake mid-cycle,
  // check registered outputs just after the next edge.
  task automatic cyc(input logic [N-1:0]    v,
                     input logic [4*N-1:0]  rds,
                     input logic [32*N-1:0] dat,
                     input logic            rv,
                     input logic [3:0]      rrd);
    int          g;
    logic [3:0]  xrd;
    logic [31:0] xd;
    logic        wr;
    logic        er;
    logic [N-1:0] erdy;
    bus.req_valid     = v;
    bus.req_rd        = rds;
    bus.req_data      = dat;
    bus.reserve_valid = rv;
    bus.reserve_rd    = rrd;
    g = -1;
    for (int k = 0; k < N; k++)
      if (g < 0 && v[(mptr + k) % N]) g = (mptr + k) % N;
    erdy = '0;
    xrd  = '0;
    xd   = '0;
    if (g >= 0) begin
      erdy[g] = 1'b1;
      xrd = rds[g*4 +: 4];
      xd  = dat[g*32 +: 32];
    end
    wr = (g >= 0) && (xrd != 4'd15);
    er = rv && (rrd != 4'd15) &&
         ((mcnt[rrd] < CMAX) || (wr && xrd == rrd));
    #4;
    chk("req_ready", bus.req_ready, erdy);
    chk("reserve_ready", bus.reserve_ready, er);
    @(posedge clk);
    #1;
    e_we    = wr;
    e_r15   = ((g >= 0) && xrd == 4'd15) || (rv && rrd == 4'd15);
    e_unres = wr && (mcnt[xrd] == 0);
    if (wr) begin
      e_rd   = xrd;
      e_data = xd;
    end
    for (int r = 0; r < 16; r++) begin
      int d;
      d = ((er && rrd == 4'(r)) ? 1 : 0) -
          ((wr && xrd == 4'(r)) ? 1 : 0);
      mcnt[r] = (mcnt[r] + d < 0) ? 0 : mcnt[r] + d;
    end
    if (g >= 0) mptr = (g + 1) % N;
    chk_regs();
  endtask

  task automatic idle();
    cyc('0, '0, '0, 1'b0, 4'd0);
  endtask

  task automatic rsv(input logic [3:0] r);
    cyc('0, '0, '0, 1'b1, r);
  endtask

  initial begin
    bus.req_valid     = '0;
    bus.req_rd        = '0;
    bus.req_data      = '0;
    bus.reserve_valid = 1'b0;
    bus.reserve_rd    = '0;
    rst_n = 1'b0;
    model_reset();
    #2;
    chk("rst_wb_we", bus.wb_we, 1'b0);
    chk("rst_wb_rd", bus.wb_rd, 4'd0);
    chk("rst_wb_data", bus.wb_data, 32'd0);
    chk("rst_err_r15", bus.err_r15, 1'b0);
    chk("rst_err_unres", bus.err_unres, 1'b0);
    chk("rst_busy", bus.busy, 16'd0);
    chk("rst_req_ready", bus.req_ready, 3'd0);
    #10 rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Reserve R3 then requester 1 writes it
    rsv(4'd3);
    chk("busy3_set", bus.busy[3], 1'b1);
    cyc(3'b010, {4'd0, 4'd3, 4'd0},
        {32'd0, 32'hDEADBEEF, 32'd0}, 1'b0, 4'd0);
    chk("t1_wb_rd", bus.wb_rd, 4'd3);
    chk("t1_wb_data", bus.wb_data, 32'hDEADBEEF);
    chk("busy3_clr", bus.busy[3], 1'b0);

    // Continuous round-robin over three reserved destinations
    for (int i = 0; i < 2; i++) begin
      rsv(4'd1);
      rsv(4'd2);
      rsv(4'd4);
    end
    for (int i = 0; i < 6; i++)
      cyc(3'b111, {4'd4, 4'd2, 4'd1},
          {32'hC0 + i, 32'hB0 + i, 32'hA0 + i}, 1'b0, 4'd0);
    chk("rr_we", bus.wb_we, 1'b1);

    // Saturation of R5, then reserve with same-cycle write
    rsv(4'd5);
    rsv(4'd5);
    rsv(4'd5);
    rsv(4'd5);
    chk("sat_busy5", bus.busy[5], 1'b1);
    cyc(3'b001, {4'd0, 4'd0, 4'd5},
        {32'd0, 32'd0, 32'h55}, 1'b1, 4'd5);
    for (int i = 0; i < 3; i++)
      cyc(3'b001, {4'd0, 4'd0, 4'd5},
          {32'd0, 32'd0, 32'h60 + i}, 1'b0, 4'd0);
    chk("drain_busy5", bus.busy[5], 1'b0);

    // R15 write and R15 reserve
    cyc(3'b001, {4'd0, 4'd0, 4'd15},
        {32'd0, 32'd0, 32'h100}, 1'b0, 4'd0);
    chk("r15_we", bus.wb_we, 1'b0);
    chk("r15_err", bus.err_r15, 1'b1);
    idle();
    chk("r15_err_pulse", bus.err_r15, 1'b0);
    rsv(4'd15);
    chk("r15_rsv_err", bus.err_r15, 1'b1);

    // Write to unreserved R7
    cyc(3'b001, {4'd0, 4'd0, 4'd7},
        {32'd0, 32'd0, 32'h5}, 1'b0, 4'd0);
    chk("unres_flag", bus.err_unres, 1'b1);
    chk("unres_busy7", bus.busy[7], 1'b0);

    // Reset in the middle of a transfer
    rsv(4'd2);
    rsv(4'd2);
    cyc(3'b100, {4'd2, 4'd0, 4'd0},
        {32'h22, 32'd0, 32'd0}, 1'b0, 4'd0);
    bus.req_valid = 3'b100;
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    chk("mid_rst_we", bus.wb_we, 1'b0);
    chk("mid_rst_busy", bus.busy, 16'd0);
    bus.req_valid = '0;
    #2 rst_n = 1'b1;
    @(posedge clk);
    #1;
    cyc(3'b111, {4'd1, 4'd1, 4'd1},
        {32'd3, 32'd2, 32'd1}, 1'b0, 4'd0);

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      logic [4*N-1:0]  rds;
      logic [32*N-1:0] dat;
      for (int k = 0; k < N; k++) begin
        rds[k*4 +: 4]   = 4'($urandom_range(0, 15));
        dat[k*32 +: 32] = $urandom;
      end
      cyc(N'($urandom), rds, dat, 1'($urandom),
          4'($urandom_range(0, 15)));
    end

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
